// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe referee: marker/player codes, FSM
// encoding, line numbering and helpers for slicing squares out of a board image.
package ttt_pkg;

  localparam int BOARD_W   = 18;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    BLANK      = 2'b00,
    MARKER_P0  = 2'b01,
    MARKER_P1  = 2'b10,
    MARKER_BAD = 2'b11
  } marker_t;

  typedef enum logic {
    PLAYER_1 = 1'b0,
    PLAYER_2 = 1'b1
  } player_t;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_DRAW  = 3'd4
  } state_t;

  localparam logic [3:0] LINE_NONE     = 4'd0;
  localparam logic [3:0] LINE_ROW_TOP  = 4'd1;
  localparam logic [3:0] LINE_ROW_MID  = 4'd2;
  localparam logic [3:0] LINE_ROW_BOT  = 4'd3;
  localparam logic [3:0] LINE_COL_LEFT = 4'd4;
  localparam logic [3:0] LINE_COL_MID  = 4'd5;
  localparam logic [3:0] LINE_COL_RGT  = 4'd6;
  localparam logic [3:0] LINE_DIAG     = 4'd7;
  localparam logic [3:0] LINE_ANTI     = 4'd8;

  // Square k (1..9) occupies bits [2k-1:2k-2].
  function automatic logic [1:0] square(input logic [BOARD_W-1:0] b, input int k);
    return b[2*k-2 +: 2];
  endfunction

  // Three square numbers of a line, packed {first, second, third}.
  function automatic logic [11:0] line_squares(input logic [3:0] line);
    case (line)
      LINE_ROW_TOP:  return {4'd1, 4'd2, 4'd3};
      LINE_ROW_MID:  return {4'd4, 4'd5, 4'd6};
      LINE_ROW_BOT:  return {4'd7, 4'd8, 4'd9};
      LINE_COL_LEFT: return {4'd1, 4'd4, 4'd7};
      LINE_COL_MID:  return {4'd2, 4'd5, 4'd8};
      LINE_COL_RGT:  return {4'd3, 4'd6, 4'd9};
      LINE_DIAG:     return {4'd1, 4'd5, 4'd9};
      LINE_ANTI:     return {4'd3, 4'd5, 4'd7};
      default:       return 12'd0;
    endcase
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector: reports whether any line is fully
// owned by `marker` and the lowest-numbered such line.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [1:0]         marker,
  output logic               hit,
  output logic [3:0]         line
);

  logic [11:0] sq;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    hit  = 1'b0;
    line = LINE_NONE;
    sq   = '0;
    // Scan from the highest index down so the lowest winning line is kept.
    for (int i = NUM_LINES; i >= 1; i--) begin
      sq = line_squares(4'(i));
      if (square(board, int'(sq[11:8])) == marker &&
          square(board, int'(sq[7:4]))  == marker &&
          square(board, int'(sq[3:0]))  == marker) begin
        hit  = 1'b1;
        line = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ttt_referee.sv
// Tic-tac-toe referee: validates each newly placed marker against the
// registered board copy, alternates turns, and detects win/draw/new game.
module ttt_referee
  import ttt_pkg::*;
#(
  parameter int NUM_SQUARES = 9,
  parameter int MAX_MOVES   = 9
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [2*NUM_SQUARES-1:0] board,
  input  logic                     new_game,
  output logic                     player_turn,
  output logic                     board_clr,
  output logic                     game_over,
  output logic [1:0]               winner,
  output logic [3:0]               win_line,
  output logic [3:0]               move_count,
  output logic                     err
);

  state_t                   state;
  logic [2*NUM_SQUARES-1:0] board_q;
  logic [1:0]               turn_marker;
  logic [3:0]               diff_cnt;
  logic [3:0]               good_cnt;
  logic                     move_legal;
  logic                     move_illegal;
  logic                     line_hit;
  logic [3:0]               line_idx;

  assign turn_marker = (player_turn == PLAYER_2) ? MARKER_P1 : MARKER_P0;

  // A legal move is exactly one changed square, going blank -> mover's marker.
  always_comb begin
    diff_cnt = '0;
    good_cnt = '0;
    for (int k = 1; k <= NUM_SQUARES; k++) begin
      if (square(board, k) != square(board_q, k)) begin
        diff_cnt = diff_cnt + 4'd1;
        if (square(board_q, k) == BLANK && square(board, k) == turn_marker)
          good_cnt = good_cnt + 4'd1;
      end
    end
  end

  assign move_legal   = (diff_cnt == 4'd1) && (good_cnt == 4'd1);
  assign move_illegal = (diff_cnt != 4'd0) && !move_legal;

  ttt_line_check u_line_check (
    .board  (board_q),
    .marker (turn_marker),
    .hit    (line_hit),
    .line   (line_idx)
  );

  always_ff @(posedge clk) begin
    // NOTE: all state and outputs use non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!clr_n) begin
      state       <= S_CLEAR;
      board_q     <= '0;
      player_turn <= PLAYER_1;
      board_clr   <= 1'b0;
      game_over   <= 1'b0;
      winner      <= BLANK;
      win_line    <= LINE_NONE;
      move_count  <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          board_q <= board;
          // board_clr doubles as "CLEAR has lasted a cycle" after reset.
          if (board_clr && board == '0) begin
            state     <= S_PLAY;
            board_clr <= 1'b0;
          end else begin
            board_clr <= 1'b1;
          end
        end
        S_PLAY: begin
          board_q <= board;
          if (move_legal) begin
            move_count <= move_count + 4'd1;
            state      <= S_CHECK;
          end else if (move_illegal) begin
            err <= 1'b1;
          end
        end
        S_CHECK: begin
          if (line_hit) begin
            state     <= S_WIN;
            game_over <= 1'b1;
            winner    <= turn_marker;
            win_line  <= line_idx;
          end else if (move_count == 4'(MAX_MOVES)) begin
            state     <= S_DRAW;
            game_over <= 1'b1;
          end else begin
            player_turn <= ~player_turn;
            state       <= S_PLAY;
          end
        end
        S_WIN, S_DRAW: begin
          if (board != board_q)
            err <= 1'b1;
        end
        default: state <= S_CLEAR;
      endcase

      // Placed last so a restart overrides any move or error decided above.
      if (new_game && (state == S_PLAY || state == S_WIN || state == S_DRAW)) begin
        state       <= S_CLEAR;
        board_clr   <= 1'b1;
        player_turn <= PLAYER_1;
        game_over   <= 1'b0;
        winner      <= BLANK;
        win_line    <= LINE_NONE;
        move_count  <= '0;
        err         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ttt_referee.sv
// Directed self-checking bench for ttt_referee: turn sequencing, win, draw,
// illegal changes, restart and reset behaviour against hand-computed outputs.
module tb_ttt_referee;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [17:0] board;
  logic        new_game;
  logic        player_turn;
  logic        board_clr;
  logic        game_over;
  logic [1:0]  winner;
  logic [3:0]  win_line;
  logic [3:0]  move_count;
  logic        err;

  int checks   = 0;
  int failures = 0;

  ttt_referee dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .board       (board),
    .new_game    (new_game),
    .player_turn (player_turn),
    .board_clr   (board_clr),
    .game_over   (game_over),
    .winner      (winner),
    .win_line    (win_line),
    .move_count  (move_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sq(input int k, input logic [1:0] m);
    board[2*k-2 +: 2] = m;
  endtask

  // Compare the full output vector {turn, clr, over, winner, line, count, err}.
  task automatic expect_outs(input string tag, input logic pt, input logic bc,
                             input logic go, input logic [1:0] w,
                             input logic [3:0] wl, input logic [3:0] mc,
                             input logic e);
    logic [13:0] obs;
    logic [13:0] exp_v;
    obs   = {player_turn, board_clr, game_over, winner, win_line, move_count, err};
    exp_v = {pt, bc, go, w, wl, mc, e};
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed pt=%b clr=%b over=%b win=%b line=%0d cnt=%0d err=%b expected pt=%b clr=%b over=%b win=%b line=%0d cnt=%0d err=%b",
             tag, obs[13], obs[12], obs[11], obs[10:9], obs[8:5], obs[4:1], obs[0],
             exp_v[13], exp_v[12], exp_v[11], exp_v[10:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
  endtask

  // Place a marker and let the two-cycle turn latency elapse.
  task automatic move(input int k, input logic [1:0] m);
    set_sq(k, m);
    step();
    step();
  endtask

  // Pulse new_game with the board held, then clear the board so CLEAR exits.
  task automatic restart();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    board    = '0;
    step();
  endtask

  initial begin
    clr_n    = 1'b0;
    board    = '0;
    new_game = 1'b0;
    step();
    step();
    expect_outs("reset_state", 0, 0, 0, 2'b00, 0, 0, 0);

    clr_n = 1'b1;
    step();
    expect_outs("clear_after_reset", 0, 1, 0, 2'b00, 0, 0, 0);
    step();
    expect_outs("play_ready", 0, 0, 0, 2'b00, 0, 0, 0);

    // Game 1: player 0 takes the top row.
    set_sq(1, 2'b01);
    step();
    expect_outs("move1_count_edge", 0, 0, 0, 2'b00, 0, 1, 0);
    step();
    expect_outs("move1_turn_edge", 1, 0, 0, 2'b00, 0, 1, 0);
    move(4, 2'b10);
    expect_outs("move2", 0, 0, 0, 2'b00, 0, 2, 0);
    move(2, 2'b01);
    expect_outs("move3", 1, 0, 0, 2'b00, 0, 3, 0);
    move(5, 2'b10);
    expect_outs("move4", 0, 0, 0, 2'b00, 0, 4, 0);
    move(3, 2'b01);
    expect_outs("win_row_top", 0, 0, 1, 2'b01, 1, 5, 0);

    // Board change while game is over is flagged.
    set_sq(9, 2'b01);
    step();
    expect_outs("change_after_win", 0, 0, 1, 2'b01, 1, 5, 1);

    // Restart with a dirty board: CLEAR holds until the board is blank.
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    expect_outs("restart_clear", 0, 1, 0, 2'b00, 0, 0, 0);
    step();
    expect_outs("clear_holds_dirty", 0, 1, 0, 2'b00, 0, 0, 0);
    board = '0;
    step();
    expect_outs("clear_exit", 0, 0, 0, 2'b00, 0, 0, 0);

    // Game 2: full board with no line.
    move(1, 2'b01);
    move(2, 2'b10);
    move(3, 2'b01);
    move(5, 2'b10);
    move(4, 2'b01);
    move(6, 2'b10);
    move(8, 2'b01);
    expect_outs("draw_move7", 1, 0, 0, 2'b00, 0, 7, 0);
    move(7, 2'b10);
    move(9, 2'b01);
    expect_outs("draw", 0, 0, 1, 2'b00, 0, 9, 0);
    restart();
    expect_outs("after_draw_restart", 0, 0, 0, 2'b00, 0, 0, 0);

    // Illegal: two squares at once.
    set_sq(1, 2'b01);
    set_sq(2, 2'b01);
    step();
    expect_outs("double_set", 0, 0, 0, 2'b00, 0, 0, 1);
    step();
    expect_outs("err_sticky", 0, 0, 0, 2'b00, 0, 0, 1);
    restart();
    expect_outs("err_cleared", 0, 0, 0, 2'b00, 0, 0, 0);

    // Illegal: player-1 marker on player 0's turn.
    set_sq(3, 2'b10);
    step();
    expect_outs("wrong_marker", 0, 0, 0, 2'b00, 0, 0, 1);
    restart();

    // Illegal: invalid code 2'b11.
    set_sq(5, 2'b11);
    step();
    expect_outs("invalid_code", 0, 0, 0, 2'b00, 0, 0, 1);
    restart();

    // Game 3: last move completes lines 3 and 6; lowest index wins, ahead of draw.
    move(3, 2'b01);
    move(1, 2'b10);
    move(7, 2'b01);
    move(2, 2'b10);
    move(6, 2'b01);
    move(4, 2'b10);
    move(8, 2'b01);
    move(5, 2'b10);
    move(9, 2'b01);
    expect_outs("win_double_line", 0, 0, 1, 2'b01, 3, 9, 0);
    set_sq(1, 2'b11);
    step();
    expect_outs("alter_after_win", 0, 0, 1, 2'b01, 3, 9, 1);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    expect_outs("restart_clears_err", 0, 1, 0, 2'b00, 0, 0, 0);
    step();
    step();
    expect_outs("clear_held", 0, 1, 0, 2'b00, 0, 0, 0);
    board = '0;
    step();
    expect_outs("clear_done", 0, 0, 0, 2'b00, 0, 0, 0);

    // Reset during CHECK.
    set_sq(1, 2'b01);
    step();
    expect_outs("in_check", 0, 0, 0, 2'b00, 0, 1, 0);
    clr_n = 1'b0;
    step();
    expect_outs("reset_mid_check", 0, 0, 0, 2'b00, 0, 0, 0);
    clr_n = 1'b1;
    step();
    expect_outs("post_reset_clear", 0, 1, 0, 2'b00, 0, 0, 0);
    board = '0;
    step();
    expect_outs("post_reset_play", 0, 0, 0, 2'b00, 0, 0, 0);

    // new_game coincident with a legal move: restart wins, move discarded.
    set_sq(1, 2'b01);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    expect_outs("newgame_vs_move", 0, 1, 0, 2'b00, 0, 0, 0);
    board = '0;
    step();

    // new_game during CHECK is ignored.
    set_sq(5, 2'b01);
    step();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    expect_outs("newgame_in_check", 1, 0, 0, 2'b00, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
